// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding request/response fetch from
// a variable-latency memory, and an in-order queue of {instruction, PC+4} for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    output logic [31:0] instruction_out,
    output logic [31:0] PCPlus4_out
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc4   [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    logic [31:0]   w_redirect_pc;

    assign w_not_empty   = (r_count != '0);
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    // RESET gates the request directly so nothing is offered while reset is held.
    assign imem_req  = !RESET && (r_state == S_REQ) && (r_count < FULL_COUNT);
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;

    // A redirect kills both the returning word and the head pop in its cycle.
    assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_pop  = w_not_empty && !StallD && !redirect;

    assign valid_out       = w_not_empty;
    assign instruction_out = w_not_empty ? r_q_instr[r_rd_ptr] : '0;
    assign PCPlus4_out     = w_not_empty ? r_q_pc4[r_rd_ptr]   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_accept) begin
                r_req_pc <= r_pc;
            end

            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state <= redirect ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end else if (redirect) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; r_count gates every read, so stale
    // contents are never visible and the array can map to plain flops/RAM.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc4[r_wr_ptr]   <= r_req_pc + 32'd4;
        end
    end

endmodule
